// File: rtl/cla_wide_seq.sv
// cla_wide_seq: multi-cycle wide-operand add sequencer.
// Streams 32*WORDS-bit operands through one external combinational 32-bit adder,
// one chunk per cycle with the LSB chunk first. The inter-chunk carry is kept in a
// register and derived from chunk MSBs, because the adder has no carry-out port.
// Optional feature: define SUB_EN to add the in_sub port (A-B via ~B and carry-in 1).
module cla_wide_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*WORDS-1:0] in_a,
    input  logic [32*WORDS-1:0] in_b,
    input  logic                in_cin,
`ifdef SUB_EN
    input  logic                in_sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*WORDS-1:0] out_sum,
    output logic                out_cout,
    output logic                out_overflow,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    output logic                add_cin,
    input  logic [31:0]         add_sum,
    output logic                busy
);

    localparam int unsigned W    = 32 * WORDS;
    localparam int unsigned IdxW = $clog2(WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            sub_q, sub_d;

    // Subtract request; tied low when the feature is not built in.
    logic sub_in;
`ifdef SUB_EN
    assign sub_in = in_sub;
`else
    assign sub_in = 1'b0;
`endif

    logic [31:0] a_chunk;
    logic [31:0] b_chunk;
    logic [31:0] b_eff;
    logic        chunk_cout;

    // Select the operand chunk for the current index; invert B when subtracting.
    always_comb begin
        a_chunk    = a_q[32*idx_q +: 32];
        b_chunk    = b_q[32*idx_q +: 32];
        b_eff      = sub_q ? ~b_chunk : b_chunk;
        // Carry out of a 32-bit add recovered from the MSBs of operands and sum.
        chunk_cout = (a_chunk[31] & b_eff[31]) | ((a_chunk[31] ^ b_eff[31]) & ~add_sum[31]);
    end

    // Next-state and output decode for the sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        sub_d     = sub_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        add_a     = 32'h0;
        add_b     = 32'h0;
        add_cin   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = ~rst;
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = sub_in;
                    // Subtraction supplies the +1 of the two's complement; in_cin is ignored.
                    carry_d = sub_in ? 1'b1 : in_cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                add_a   = a_chunk;
                add_b   = b_eff;
                add_cin = carry_q;
                sum_d[32*idx_q +: 32] = add_sum;
                carry_d = chunk_cout;
                if (idx_q == LastIdx) begin
                    cout_d  = chunk_cout;
                    // Signed overflow judged on the top chunk as presented to the adder.
                    ovf_d   = ~(a_chunk[31] ^ b_eff[31]) & (add_sum[31] ^ a_chunk[31]);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            sub_q   <= sub_d;
        end
    end

    // Result registers are presented directly; they only change in RUN.
    assign out_sum      = sum_q;
    assign out_cout     = cout_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_cla_wide_seq.sv
// Testbench for cla_wide_seq with WORDS=4 and a behavioural 32-bit adder.
// Expected results come from full-width arithmetic on the operands.
module tb_cla_wide_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = 32 * WORDS;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_cin;
`ifdef SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_cout;
    logic             out_overflow;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_cin;
    logic [31:0]      add_sum;
    logic             busy;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    cla_wide_seq #(
        .WORDS(WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
`ifdef SUB_EN
        .in_sub      (in_sub),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_overflow(out_overflow),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .busy        (busy)
    );

    // External adder: plain 32-bit modular sum.
    assign add_sum = add_a + add_b + {31'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passes = passes + 1;
        end else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full-width reference: A + Beff + c, with signed overflow from operand/result signs.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         input logic sub, output logic [N-1:0] s, output logic co,
                         output logic ov);
        logic [N:0]   t;
        logic [N-1:0] beff;
        beff = sub ? ~b : b;
        t    = {1'b0, a} + {1'b0, beff} + {{N{1'b0}}, (sub ? 1'b1 : cin)};
        s    = t[N-1:0];
        co   = t[N];
        ov   = (a[N-1] == beff[N-1]) && (s[N-1] != a[N-1]);
    endtask

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] r;
        for (int i = 0; i < int'(WORDS); i++) begin
            case ($urandom_range(0, 5))
                0:       r[i*32 +: 32] = 32'hFFFF_FFFF;
                1:       r[i*32 +: 32] = 32'h0;
                2:       r[i*32 +: 32] = 32'h7FFF_FFFF;
                3:       r[i*32 +: 32] = 32'h8000_0000;
                default: r[i*32 +: 32] = $urandom();
            endcase
        end
        return r;
    endfunction

    task automatic set_sub(input logic s);
`ifdef SUB_EN
        in_sub = s;
`else
        if (s) $display("note: subtract requested without SUB_EN");
`endif
    endtask

    // One complete transaction: accept, wait for result, optionally stall, release.
    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                           input logic sub, input int hold, input bit pulse,
                           output logic [WORDS-1:0] cin_seen);
        logic [N-1:0] es;
        logic         ec;
        logic         eo;
        int           lat;
        bit           stable;
        model(a, b, cin, sub, es, ec, eo);
        cin_seen = '0;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        set_sub(sub);
        @(negedge clk);
        // Scramble operands after the accept edge; they must not matter.
        in_valid = 1'b0;
        in_a     = rnd();
        in_b     = rnd();
        in_cin   = 1'($urandom());
        lat      = 0;
        while (!out_valid && lat < 4 * int'(WORDS)) begin
            if (lat < int'(WORDS)) cin_seen[lat] = add_cin;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, WORDS);
        chk("out_sum", out_sum, es);
        chk("out_cout", out_cout, ec);
        chk("out_overflow", out_overflow, eo);
        chk("done_ready_busy", {in_ready, busy}, 2'b01);
        chk("bus_quiet_done", {add_a, add_b, add_cin}, 0);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid = i[0];
                in_a     = rnd();
                in_b     = rnd();
            end
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sum !== es || out_cout !== ec ||
                out_overflow !== eo || in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) chk("hold_stable", stable, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("released", {out_valid, busy, in_ready}, 3'b001);
    endtask

    logic [WORDS-1:0] seen;
    logic [N-1:0]     ra;
    logic [N-1:0]     rb;
    logic             rs;
    bit               quiet;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        set_sub(1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {in_ready, out_valid, busy, out_cout, out_overflow, add_cin}, 0);
        chk("reset_sum", out_sum, 0);
        chk("reset_bus", {add_a, add_b}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {in_ready, busy, out_valid}, 3'b100);

        // Full wrap to zero with carry out.
        run_txn(128'd1, {N{1'b1}}, 1'b0, 1'b0, 0, 1'b0, seen);
        // Chunk-0 carry feeds chunk 1 only.
        run_txn(128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, 0, 1'b0, seen);
        chk("t2_cin_chain", seen, 4'b0010);
        // Max positive + 1 overflows.
        run_txn({1'b0, {(N-1){1'b1}}}, 128'd1, 1'b0, 1'b0, 0, 1'b0, seen);
        // Stall in DONE for 10 cycles with in_valid pulsed.
        run_txn(rnd(), rnd(), 1'b1, 1'b0, 10, 1'b1, seen);
        @(negedge clk);
        chk("pulse_dropped", {busy, out_valid, in_ready}, 3'b001);

        // Asynchronous reset during RUN cycle 2.
        in_valid = 1'b1;
        in_a     = rnd();
        in_b     = rnd();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {in_ready, out_valid, busy, out_cout, out_overflow, add_cin}, 0);
        chk("rst_mid_data", {add_a, add_b, out_sum}, 0);
        @(negedge clk);
        rst   = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("no_partial_result", quiet, 1);
        run_txn(128'd3, 128'd4, 1'b0, 1'b0, 0, 1'b0, seen);

`ifdef SUB_EN
        run_txn(128'd5, 128'd7, 1'b1, 1'b1, 0, 1'b0, seen);
`endif

        // out_ready without out_valid does nothing.
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("stray_out_ready", {in_ready, busy, out_valid}, 3'b100);

        // Randomized transactions against the full-width model.
        for (int k = 0; k < 20; k++) begin
            ra = rnd();
            rb = rnd();
`ifdef SUB_EN
            rs = 1'($urandom());
`else
            rs = 1'b0;
`endif
            run_txn(ra, rb, 1'($urandom()), rs, $urandom_range(0, 2), 1'($urandom()), seen);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
